reg_wb_seq: RTL and testbench

- Writeback sequencer: the write side of the CPU register file.
- Accepts completed-instruction results from the EX/MEM stage over a valid/ready handshake and buffers them in a small FIFO.
- Drives the register file's write port (we/wa/wd) and its branch port (ib/bv/bl), one operation per cycle.
- Splits a branch-with-link, or a write-plus-branch, into two ordered cycles.

---
 rtl/reg_wb_seq.sv | 181 ++++++++++++++++++
 tb/tb_reg_wb_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_seq.sv
// Writeback sequencer: buffers EX/MEM results and drives the register file write and branch ports.
// Optional REG_WB_BYPASS_EN lets an entry skip the FIFO when the sequencer is idle and empty.
//
// state | meaning
// IDLE  | pop the FIFO head (or take the bypassed entry) and issue its first op
// PEND2 | issue the latched branch of a write-plus-branch entry; no pop
module reg_wb_seq #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [3:0]  in_dest,
  input  logic [31:0] in_data,
  input  logic        in_byte,
  input  logic [1:0]  in_addr_lo,
  input  logic        in_link,
  input  logic [31:0] in_link_pc,
  input  logic        in_branch,
  input  logic [31:0] in_target,
  output logic        we,
  output logic [3:0]  wa,
  output logic [31:0] wd,
  output logic        ib,
  output logic [31:0] bv,
  output logic        bl,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, PEND2 = 1'b1} state_t;

  // Entries are decoded on the way in, so the FIFO holds ready-to-issue ops.
  typedef struct packed {
    logic        has_w;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        has_b;
    logic [31:0] bv;
    logic        bl;
  } op_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  op_t             mem_q [DEPTH];
  op_t             mem_d [DEPTH];
  logic            we_q, we_d, ib_q, ib_d, bl_q, bl_d, pbl_q, pbl_d;
  logic [3:0]      wa_q, wa_d;
  logic [31:0]     wd_q, wd_d, bv_q, bv_d, pbv_q, pbv_d;

  op_t             in_op, cur_op;
  logic [7:0]      byte_val;
  logic            full, empty, push, pop, bypass, fifo_push, issue;

  always_comb begin
    byte_val    = in_data[{in_addr_lo, 3'b000} +: 8];
    in_op.has_w = in_wen | in_link;
    in_op.wa    = in_link ? 4'd14 : in_dest;
    in_op.wd    = in_link ? in_link_pc : (in_byte ? {24'b0, byte_val} : in_data);
    in_op.has_b = in_branch;
    in_op.bv    = in_target;
    in_op.bl    = in_link;
  end

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full & !flush & reset;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == IDLE) & !empty & !flush;

`ifdef REG_WB_BYPASS_EN
  assign bypass = push & empty & (state_q == IDLE);
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push & !bypass;
  assign issue     = pop | bypass;
  assign cur_op    = pop ? mem_q[rd_ptr_q] : in_op;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_push) begin
        mem_d[wr_ptr_q] = in_op;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(fifo_push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    ib_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    bv_d    = bv_q;
    bl_d    = bl_q;
    pbv_d   = pbv_q;
    pbl_d   = pbl_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == PEND2) begin
      ib_d    = 1'b1;
      bv_d    = pbv_q;
      bl_d    = pbl_q;
      state_d = IDLE;
    end else if (issue) begin
      if (cur_op.has_w) begin
        we_d = 1'b1;
        wa_d = cur_op.wa;
        wd_d = cur_op.wd;
        if (cur_op.has_b) begin
          pbv_d   = cur_op.bv;
          pbl_d   = cur_op.bl;
          state_d = PEND2;
        end
      end else if (cur_op.has_b) begin
        ib_d = 1'b1;
        bv_d = cur_op.bv;
        bl_d = cur_op.bl;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      ib_q     <= 1'b0;
      bv_q     <= '0;
      bl_q     <= 1'b0;
      pbv_q    <= '0;
      pbl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      ib_q     <= ib_d;
      bv_q     <= bv_d;
      bl_q     <= bl_d;
      pbv_q    <= pbv_d;
      pbl_q    <= pbl_d;
    end
  end

  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign ib   = ib_q;
  assign bv   = bv_q;
  assign bl   = bl_q;
  assign busy = !empty | (state_q == PEND2);

endmodule

// File: tb/tb_reg_wb_seq.sv
// Directed self-checking bench for reg_wb_seq (DEPTH=2), covering both the FIFO and bypass builds.
module tb_reg_wb_seq;

`ifdef REG_WB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic        in_wen, in_byte, in_link, in_branch;
  logic [3:0]  in_dest;
  logic [31:0] in_data, in_link_pc, in_target;
  logic [1:0]  in_addr_lo;
  logic        we, ib, bl, busy;
  logic [3:0]  wa;
  logic [31:0] wd, bv;

  int errors = 0;
  int checks = 0;

  reg_wb_seq #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_dest(in_dest), .in_data(in_data),
    .in_byte(in_byte), .in_addr_lo(in_addr_lo),
    .in_link(in_link), .in_link_pc(in_link_pc),
    .in_branch(in_branch), .in_target(in_target),
    .we(we), .wa(wa), .wd(wd), .ib(ib), .bv(bv), .bl(bl), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_wen = 0; in_dest = 0; in_data = 0; in_byte = 0;
    in_addr_lo = 0; in_link = 0; in_link_pc = 0; in_branch = 0; in_target = 0;
  endtask

  task automatic drive(input logic wen, input logic [3:0] dest, input logic [31:0] data,
                       input logic byt, input logic [1:0] lo, input logic link,
                       input logic [31:0] lpc, input logic br, input logic [31:0] tgt);
    in_valid = 1; in_wen = wen; in_dest = dest; in_data = data; in_byte = byt;
    in_addr_lo = lo; in_link = link; in_link_pc = lpc; in_branch = br; in_target = tgt;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({we, wa, wd, ib, bv, bl, in_ready, busy} !== 73'd0) begin
      errors++;
      $display("FAIL reset_hold: got we=%b wa=%h wd=%h ib=%b bv=%h bl=%b rdy=%b busy=%b, want all 0",
               we, wa, wd, ib, bv, bl, in_ready, busy);
    end
    @(negedge clk); reset = 1;
    step();
    checks++;
    if ({in_ready, busy, we, ib} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b we=%b ib=%b, want 1 0 0 0", in_ready, busy, we, ib);
    end
  endtask

  task automatic test_write();
    drive(1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, wa, wd, ib} !== {1'b1, 4'd3, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL write_issue: got we=%b wa=%0d wd=%h ib=%b, want 1 3 deadbeef 0", we, wa, wd, ib);
    end
    step();
    checks++;
    if ({we, wa, wd, busy} !== {1'b0, 4'd3, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL write_single: got we=%b wa=%0d wd=%h busy=%b, want 0 3 deadbeef 0", we, wa, wd, busy);
    end
  endtask

  task automatic test_byte();
    drive(1, 4'd5, 32'h11223344, 1, 2'd2, 0, 0, 0, 0);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, wa, wd} !== {1'b1, 4'd5, 32'h00000022}) begin
      errors++;
      $display("FAIL byte_load: got we=%b wa=%0d wd=%h, want 1 5 00000022", we, wa, wd);
    end
    step();
  endtask

  task automatic test_link_branch();
    drive(0, 4'd7, 32'h55, 0, 0, 1, 32'h104, 1, 32'h200);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, wa, wd, ib} !== {1'b1, 4'd14, 32'h104, 1'b0}) begin
      errors++;
      $display("FAIL bl_write: got we=%b wa=%0d wd=%h ib=%b, want 1 14 00000104 0", we, wa, wd, ib);
    end
    step();
    checks++;
    if ({we, ib, bv, bl} !== {1'b0, 1'b1, 32'h200, 1'b1}) begin
      errors++;
      $display("FAIL bl_branch: got we=%b ib=%b bv=%h bl=%b, want 0 1 00000200 1", we, ib, bv, bl);
    end
    step();
    checks++;
    if ({we, ib, busy, bv} !== {3'b000, 32'h200}) begin
      errors++;
      $display("FAIL bl_done: got we=%b ib=%b busy=%b bv=%h, want 0 0 0 00000200", we, ib, busy, bv);
    end
  endtask

  task automatic test_branch();
    drive(0, 4'd0, 0, 0, 0, 0, 0, 1, 32'h300);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, ib, bv, bl} !== {1'b0, 1'b1, 32'h300, 1'b0}) begin
      errors++;
      $display("FAIL branch_only: got we=%b ib=%b bv=%h bl=%b, want 0 1 00000300 0", we, ib, bv, bl);
    end
    drive(1, 4'd2, 32'hCAFE0002, 0, 0, 0, 0, 1, 32'h400);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, wa, wd, ib} !== {1'b1, 4'd2, 32'hCAFE0002, 1'b0}) begin
      errors++;
      $display("FAIL wb_write: got we=%b wa=%0d wd=%h ib=%b, want 1 2 cafe0002 0", we, wa, wd, ib);
    end
    step();
    checks++;
    if ({we, ib, bv, bl} !== {1'b0, 1'b1, 32'h400, 1'b0}) begin
      errors++;
      $display("FAIL wb_branch: got we=%b ib=%b bv=%h bl=%b, want 0 1 00000400 0", we, ib, bv, bl);
    end
    drive(0, 4'd6, 32'h77, 0, 0, 0, 32'h88, 0, 32'h99);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, ib, busy, wa, bv} !== {3'b000, 4'd2, 32'h400}) begin
      errors++;
      $display("FAIL silent_entry: got we=%b ib=%b busy=%b wa=%0d bv=%h, want 0 0 0 2 00000400",
               we, ib, busy, wa, bv);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  dst [4] = '{4'd1, 4'd4, 4'd9, 4'd12};
    logic [31:0] dat [4] = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    int sent = 0, rcv = 0, cyc = 0, first = -1, last = -1, extra = 0;
    logic acc;
    while ((sent < 4 || rcv < 4) && cyc < 40) begin
      if (sent < 4) drive(1, dst[sent], dat[sent], 0, 0, 0, 0, 0, 0);
      else idle_in();
      acc = in_valid & in_ready;
      step(); cyc++;
      if (acc) sent++;
      if (we) begin
        checks++;
        if ({wa, wd} !== {dst[rcv], dat[rcv]}) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got wa=%0d wd=%h, want %0d %h", rcv, wa, wd, dst[rcv], dat[rcv]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        rcv++;
      end
    end
    idle_in();
    repeat (4) begin step(); if (we || ib) extra++; end
    checks++;
    if (rcv !== 4 || (last - first) !== 3 || extra !== 0) begin
      errors++;
      $display("FAIL b2b_count: got rcv=%0d span=%0d extra=%0d, want 4 3 0", rcv, last - first, extra);
    end
  endtask

  task automatic test_full();
    logic [31:0] lpc [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    logic [31:0] tgt [4] = '{32'h1100, 32'h2200, 32'h3300, 32'h4400};
    int sent = 0, k = 0, cyc = 0, both = 0;
    logic acc, saw_full = 0;
    while ((sent < 4 || k < 8) && cyc < 60) begin
      if (sent < 4) drive(0, 4'd0, 0, 0, 0, 1, lpc[sent], 1, tgt[sent]);
      else idle_in();
      if (sent < 4 && !in_ready) saw_full = 1;
      acc = in_valid & in_ready;
      step(); cyc++;
      if (acc) sent++;
      if (we && ib) both++;
      if ((we || ib) && k < 8) begin
        checks++;
        if (k % 2 == 0) begin
          if ({we, ib, wa, wd} !== {2'b10, 4'd14, lpc[k/2]}) begin
            errors++;
            $display("FAIL full_op[%0d]: got we=%b ib=%b wa=%0d wd=%h, want 1 0 14 %h", k, we, ib, wa, wd, lpc[k/2]);
          end
        end else begin
          if ({we, ib, bv, bl} !== {2'b01, tgt[k/2], 1'b1}) begin
            errors++;
            $display("FAIL full_op[%0d]: got we=%b ib=%b bv=%h bl=%b, want 0 1 %h 1", k, we, ib, bv, bl, tgt[k/2]);
          end
        end
        k++;
      end
    end
    idle_in();
    step();
    checks++;
    if (saw_full !== 1'b1 || k !== 8 || both !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_summary: got saw_full=%b ops=%0d both=%0d busy=%b, want 1 8 0 0", saw_full, k, both, busy);
    end
  endtask

  task automatic test_flush();
    int strobes = 0;
    drive(0, 4'd0, 0, 0, 0, 1, 32'h500, 1, 32'h600);
    step();
    drive(0, 4'd0, 0, 0, 0, 1, 32'h700, 1, 32'h800);
    step();
    drive(1, 4'd9, 32'h99999999, 0, 0, 0, 0, 0, 0);
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got in_ready=%b, want 0", in_ready);
    end
    step();
    flush = 0; idle_in();
    checks++;
    if ({we, ib, busy} !== 3'b000) begin
      errors++;
      $display("FAIL flush_clear: got we=%b ib=%b busy=%b, want 0 0 0", we, ib, busy);
    end
    repeat (6) begin step(); if (we || ib || busy) strobes++; end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL flush_quiet: got %0d active cycles after flush, want 0", strobes);
    end
  endtask

  task automatic test_reset_pend2();
    int pulses = 0;
    drive(0, 4'd0, 0, 0, 0, 1, 32'hABC0, 1, 32'hDEF0);
    step(); idle_in();
    repeat (LAT) step();
    checks++;
    if ({we, wa, busy} !== {1'b1, 4'd14, 1'b1}) begin
      errors++;
      $display("FAIL rst_setup: got we=%b wa=%0d busy=%b, want 1 14 1", we, wa, busy);
    end
    #1 reset = 0;
    #1;
    checks++;
    if ({we, wa, wd, ib, bv, bl, in_ready, busy} !== 73'd0) begin
      errors++;
      $display("FAIL rst_mid: got we=%b wa=%h wd=%h ib=%b bv=%h bl=%b rdy=%b busy=%b, want all 0",
               we, wa, wd, ib, bv, bl, in_ready, busy);
    end
    @(negedge clk); reset = 1;
    step();
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_after: got rdy=%b busy=%b, want 1 0", in_ready, busy);
    end
    repeat (3) begin if (ib) pulses++; step(); end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_no_ib: got %0d ib pulses, want 0", pulses);
    end
  endtask

  initial begin
    reset = 0; flush = 0;
    idle_in();
    test_reset();
    test_write();
    test_byte();
    test_link_branch();
    test_branch();
    test_back_to_back();
    test_full();
    test_flush();
    test_reset_pend2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
